// File: rtl/shreg_pkg.sv
// shreg_pkg: shared definitions for the universal shift register.
//   SHREG_MODE_W : width of the mode select
//   shreg_mode_e : hold / shift right / shift left / parallel load
package shreg_pkg;

    localparam int SHREG_MODE_W = 2;

    typedef enum logic [SHREG_MODE_W-1:0] {
        SHREG_HOLD = 2'b00,
        SHREG_SHR  = 2'b01,
        SHREG_SHL  = 2'b10,
        SHREG_LOAD = 2'b11
    } shreg_mode_e;

endpackage

// File: rtl/shreg_shift_counter.sv
// shreg_shift_counter: counts shifts since the last load/reset, saturating
// at WIDTH, and pulses done for one cycle on the shift that reaches WIDTH.
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   clr   in  synchronous clear (parallel load)
//   inc   in  one shift happens on this edge
//   count out shifts since last clear, saturating at WIDTH
//   done  out registered one-cycle completion pulse
module shreg_shift_counter #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         inc,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q, count_d;
    logic          done_q,  done_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != FULL)) begin
            count_d = count_q + CW'(1);
            // Only the transition into saturation completes a transfer.
            done_d  = (count_q == LAST);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule

// File: rtl/shreg_universal.sv
// shreg_universal: WIDTH-bit universal shift register with hold, shift right,
// shift left and parallel load, complementary outputs and a full-word
// transfer counter.
//   clk   in  clock
//   rst   in  asynchronous active-high reset (q <= RESET_VAL)
//   mode  in  00 hold, 01 shift right, 10 shift left, 11 load
//   sin   in  serial input for shift modes
//   rot   in  rotate request (only honoured when SHREG_ROTATE_EN is defined)
//   d     in  parallel load data
//   q     out register contents
//   qbar  out ~q
//   sout  out q[WIDTH-1] in shift-left mode, otherwise q[0]
//   count out shifts since last load/reset, saturating at WIDTH
//   done  out one-cycle pulse after the WIDTH-th shift
// Build option: define SHREG_ROTATE_EN to enable rotate on rot = 1.
module shreg_universal
    import shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SHREG_MODE_W-1:0]    mode,
    input  logic                       sin,
    input  logic                       rot,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qbar,
    output logic                       sout,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                       done
);

    shreg_mode_e      mode_e;
    logic [WIDTH-1:0] q_q, q_d;
    logic             fill_r, fill_l;
    logic             shifting;

    assign mode_e = shreg_mode_e'(mode);

`ifdef SHREG_ROTATE_EN
    // Rotate feeds the bit leaving one end back into the other.
    assign fill_r = rot ? q_q[0]       : sin;
    assign fill_l = rot ? q_q[WIDTH-1] : sin;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign fill_r     = sin;
    assign fill_l     = sin;
`endif

    always_comb begin
        q_d = q_q;
        case (mode_e)
            SHREG_SHR:  q_d = {fill_r, q_q[WIDTH-1:1]};
            SHREG_SHL:  q_d = {q_q[WIDTH-2:0], fill_l};
            SHREG_LOAD: q_d = d;
            default:    q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= RESET_VAL;
        else     q_q <= q_d;
    end

    assign shifting = (mode_e == SHREG_SHR) || (mode_e == SHREG_SHL);

    shreg_shift_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (mode_e == SHREG_LOAD),
        .inc   (shifting),
        .count (count),
        .done  (done)
    );

    // qbar derives from the same flops as q, so the two can never disagree.
    assign q    = q_q;
    assign qbar = ~q_q;
    assign sout = (mode_e == SHREG_SHL) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_shreg_universal.sv
// tb_shreg_universal: scoreboard bench for shreg_universal (WIDTH=8,
// RESET_VAL=8'hA5). Stimulus pushes the expected post-edge state into a
// queue; a monitor pops and compares after every rising edge.
module tb_shreg_universal;

    localparam int          W   = 8;
    localparam logic [7:0]  RV  = 8'hA5;
`ifdef SHREG_ROTATE_EN
    localparam bit          ROT_EN = 1'b1;
`else
    localparam bit          ROT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       sin, rot;
    logic [7:0] d;
    logic [7:0] q, qbar;
    logic       sout;
    logic [3:0] count;
    logic       done;

    shreg_universal #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sin(sin), .rot(rot), .d(d),
        .q(q), .qbar(qbar), .sout(sout), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] count;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    // Reference model: word as an integer, shifts counted since last load.
    int m_q;
    int m_shifts;
    bit m_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every rising edge with a pending expectation is compared.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("q",     {56'd0, q},     {56'd0, e.q});
                check("qbar",  {56'd0, qbar},  {56'd0, ~e.q});
                check("count", {60'd0, count}, {60'd0, e.count});
                check("done",  {63'd0, done},  {63'd0, e.done});
                if (done === 1'b1) done_seen++;
            end
        end
    end

    task automatic model_reset();
        m_q      = int'(RV);
        m_shifts = 0;
        m_done   = 1'b0;
    endtask

    // One clock of stimulus: drive at the falling edge, check sout, push
    // the state expected after the next rising edge.
    task automatic cycle(input logic [1:0] m, input logic s, input logic r, input logic [7:0] dd);
        int  fill;
        int  exp_sout;
        exp_t e;
        @(negedge clk);
        mode = m; sin = s; rot = r; d = dd;
        #1;
        exp_sout = (m == 2'b10) ? ((m_q >> (W-1)) & 1) : (m_q & 1);
        check("sout", {63'd0, sout}, 64'(exp_sout));
        m_done = 1'b0;
        case (m)
            2'b01: begin
                fill = (ROT_EN && r) ? (m_q & 1) : int'(s);
                m_q  = (m_q >> 1) | (fill << (W-1));
            end
            2'b10: begin
                fill = (ROT_EN && r) ? ((m_q >> (W-1)) & 1) : int'(s);
                m_q  = ((m_q << 1) | fill) & ((1 << W) - 1);
            end
            2'b11: begin
                m_q = int'(dd);
                m_shifts = 0;
            end
            default: ;
        endcase
        if (m == 2'b01 || m == 2'b10) begin
            m_done   = (m_shifts == W-1);
            m_shifts = (m_shifts < W) ? m_shifts + 1 : W;
        end
        e.q = 8'(m_q); e.count = 4'(m_shifts); e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic expect_q(input string name, input logic [7:0] req);
        @(posedge clk);
        #2;
        check(name, {56'd0, q}, {56'd0, req});
    endtask

    task automatic do_reset();
        @(negedge clk);
        mode = 2'b00;
        #2 rst = 1'b1;
        #1;
        check("async_rst_q",     {56'd0, q},     {56'd0, RV});
        check("async_rst_count", {60'd0, count}, 64'd0);
        check("async_rst_done",  {63'd0, done},  64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int          base;
    logic [7:0]  sout_seq;

    initial begin
        rst = 1'b1; mode = 2'b00; sin = 1'b0; rot = 1'b0; d = 8'h00;
        model_reset();
        #1;
        check("reset_q",     {56'd0, q},     {56'd0, 8'hA5});
        check("reset_qbar",  {56'd0, qbar},  {56'd0, 8'h5A});
        check("reset_count", {60'd0, count}, 64'd0);
        check("reset_done",  {63'd0, done},  64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load 3C, eight right shifts with sin=0.
        cycle(2'b11, 1'b0, 1'b0, 8'h3C);
        base = done_seen;
        sout_seq = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            cycle(2'b01, 1'b0, 1'b0, 8'h00);
            check("sout_seq", {63'd0, sout}, {63'd0, sout_seq[i]});
        end
        cycle(2'b00, 1'b0, 1'b0, 8'h00);
        expect_q("shr8_q", 8'h00);
        check("shr8_count", {60'd0, count}, 64'd8);
        check("shr8_done_once", 64'(done_seen - base), 64'd1);

        // Load 81, three left shifts with sin=1.
        cycle(2'b11, 1'b0, 1'b0, 8'h81);
        base = done_seen;
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b1, 1'b0, 8'h00);
        expect_q("shl3_q", 8'h0F);
        check("shl3_count", {60'd0, count}, 64'd3);
        check("shl3_no_done", 64'(done_seen - base), 64'd0);

        // Twelve right shifts: saturation, single done.
        cycle(2'b11, 1'b0, 1'b0, 8'($urandom));
        base = done_seen;
        for (int i = 0; i < 12; i++) cycle(2'b01, 1'($urandom), 1'b0, 8'h00);
        expect_q("sat_q", 8'(m_q));
        check("sat_count", {60'd0, count}, 64'd8);
        check("sat_done_once", 64'(done_seen - base), 64'd1);

        // Reset after five shifts aborts the transfer.
        cycle(2'b11, 1'b0, 1'b0, 8'h5E);
        base = done_seen;
        for (int i = 0; i < 5; i++) cycle(2'b10, 1'($urandom), 1'b0, 8'h00);
        do_reset();
        check("abort_no_done", 64'(done_seen - base), 64'd0);
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'($urandom), 1'b0, 8'h00);
        cycle(2'b00, 1'b0, 1'b0, 8'h00);
        check("after_rst_done_once", 64'(done_seen - base), 64'd1);

        // Rotate request with sin=0.
        cycle(2'b11, 1'b0, 1'b0, 8'h96);
        base = done_seen;
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b0, 1'b1, 8'h00);
        expect_q("rot_q", ROT_EN ? 8'h96 : 8'h00);
        check("rot_done_once", 64'(done_seen - base), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom_range(3)), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
